// File: rtl/simon_cfg_pkg.sv
// Shared definitions for the Simon key-schedule configuration block:
// register offsets, bit positions, AXI response codes and the CTRL layout.
package simon_cfg_pkg;

  // Byte offsets of the register map; only address bits [5:2] are decoded.
  localparam logic [5:0] KEY_BASE   = 6'h00;
  localparam logic [5:0] CTRL_OFS   = 6'h20;
  localparam logic [5:0] STATUS_OFS = 6'h24;

  // Word indices derived from the byte offsets.
  localparam logic [3:0] KEY_IDX    = KEY_BASE[5:2];
  localparam logic [3:0] CTRL_IDX   = CTRL_OFS[5:2];
  localparam logic [3:0] STATUS_IDX = STATUS_OFS[5:2];

  // CTRL bit positions.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  // STATUS bit positions.
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_FILLED_BIT  = 1;
  localparam int STAT_OVERRUN_BIT = 2;
  localparam int STAT_WORDS_LSB   = 8;

  // AXI4-Lite response encoding.
  typedef logic [1:0] axil_resp_t;
  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // CTRL write-data layout (bit 2 down to bit 0).
  typedef struct packed {
    logic clear_key;
    logic auto_start;
    logic start;
  } simon_ctrl_t;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/simon_cfg_axil.sv
// AXI4-Lite configuration slave for the Simon key schedule. Holds the
// initial key, CTRL and STATUS, issues a one-cycle start pulse to the
// key-expansion core and refuses key changes while that core is busy.
module simon_cfg_axil
  import simon_cfg_pkg::*;
#(
  parameter int KEY_WORDS  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // write data channel
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // write response channel
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // read data channel
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // key-expansion core interface
  output logic [KEY_WORDS*32-1:0] init_key,
  output logic                    key_compute_start,
  input  logic                    key_busy
);

  localparam logic [3:0] KEY_LIMIT = 4'(KEY_WORDS);

  // Write-side holding registers; AW and W are captured independently.
  logic        aw_held;
  logic [3:0]  aw_idx_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  // Register file state and its next-state values.
  logic [KEY_WORDS-1:0][31:0] key_q, key_d;
  logic [KEY_WORDS-1:0]       filled_q, filled_d;
  logic                       auto_start_q, auto_start_d;
  logic                       overrun_q, overrun_d;

  logic        commit;
  logic        start_req;
  logic        start_fire;
  logic        all_filled;
  axil_resp_t  wr_resp;
  simon_ctrl_t wr_ctrl;

  logic [3:0]  ar_idx;
  logic [31:0] rd_data;
  axil_resp_t  rd_resp;

  // Protection bits and the undecoded address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_awprot, s_arprot, s_awaddr, s_araddr};

  // One write outstanding: a channel is ready only while nothing is held for
  // it and no response is pending. Readies stay low while in reset.
  assign s_awready = !rst && !aw_held && !s_bvalid;
  assign s_wready  = !rst && !w_held  && !s_bvalid;
  assign s_arready = !rst && !s_rvalid;

  // A write is committed in the cycle after both halves are held.
  assign commit     = aw_held && w_held;
  assign wr_ctrl    = simon_ctrl_t'(w_data_q[2:0]);
  assign all_filled = &filled_q;
  assign start_fire = start_req && !key_busy;
  assign init_key   = key_q;
  assign ar_idx     = s_araddr[5:2];

  // Write decode: computes the register file update for a committing write.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    key_d        = key_q;
    filled_d     = filled_q;
    auto_start_d = auto_start_q;
    overrun_d    = overrun_q;
    start_req    = 1'b0;
    wr_resp      = RESP_OKAY;

    if (commit) begin
      if (aw_idx_q < KEY_IDX + KEY_LIMIT) begin
        // Key words are frozen while the core consumes them.
        if (key_busy) begin
          wr_resp = RESP_SLVERR;
        end else begin
          for (int i = 0; i < KEY_WORDS; i++) begin
            if (aw_idx_q == KEY_IDX + 4'(i)) begin
              key_d[i] = byte_merge(key_q[i], w_data_q, w_strb_q);
              if (|w_strb_q) filled_d[i] = 1'b1;
            end
          end
          // Auto-start only on the write that completes the key.
          if (auto_start_q && !all_filled && (&filled_d)) start_req = 1'b1;
        end
      end else if (aw_idx_q == CTRL_IDX) begin
        if (w_strb_q[0]) begin
          if (wr_ctrl.clear_key && key_busy) begin
            wr_resp = RESP_SLVERR;
          end else begin
            auto_start_d = wr_ctrl.auto_start;
            if (wr_ctrl.clear_key) begin
              // Clear takes priority and swallows a simultaneous start.
              key_d    = '0;
              filled_d = '0;
            end else if (wr_ctrl.start) begin
              start_req = 1'b1;
            end
          end
        end
      end else if (aw_idx_q == STATUS_IDX) begin
        if (w_strb_q[0] && w_data_q[STAT_OVERRUN_BIT]) overrun_d = 1'b0;
      end else begin
        wr_resp = RESP_SLVERR;
      end
    end

    // A start that cannot be honoured becomes a sticky overrun; setting
    // overrides a clear in the same cycle.
    if (start_req && key_busy) overrun_d = 1'b1;
    // Launching the core consumes the current key: filled flags restart.
    if (start_fire) filled_d = '0;
  end

  // Read decode: value and response for the address presented on AR.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_idx < KEY_IDX + KEY_LIMIT) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (ar_idx == KEY_IDX + 4'(i)) rd_data = key_q[i];
      end
    end else if (ar_idx == CTRL_IDX) begin
      rd_data[CTRL_AUTO_BIT] = auto_start_q;
    end else if (ar_idx == STATUS_IDX) begin
      rd_data[STAT_BUSY_BIT]            = key_busy;
      rd_data[STAT_FILLED_BIT]          = all_filled;
      rd_data[STAT_OVERRUN_BIT]         = overrun_q;
      rd_data[STAT_WORDS_LSB +: 4]      = 4'(KEY_WORDS);
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // AXI channel state and register file update.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      aw_held           <= 1'b0;
      aw_idx_q          <= '0;
      w_held            <= 1'b0;
      w_data_q          <= '0;
      w_strb_q          <= '0;
      s_bvalid          <= 1'b0;
      s_bresp           <= RESP_OKAY;
      s_rvalid          <= 1'b0;
      s_rdata           <= '0;
      s_rresp           <= RESP_OKAY;
      // NOTE: the key words are reset even though they form a storage array,
      // because they drive init_key whose reset value is architecturally zero.
      key_q             <= '0;
      filled_q          <= '0;
      auto_start_q      <= 1'b1;
      overrun_q         <= 1'b0;
      key_compute_start <= 1'b0;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_awaddr[5:2];
      end
      if (s_wvalid && s_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end

      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= wr_resp;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end

      key_q             <= key_d;
      filled_q          <= filled_d;
      auto_start_q      <= auto_start_d;
      overrun_q         <= overrun_d;
      key_compute_start <= start_fire;

      // Read data is sampled from pre-commit state in the same edge.
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_data;
        s_rresp  <= rd_resp;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simon_cfg_axil.sv
// Directed bench for simon_cfg_axil with KEY_WORDS=4. Stimulus tasks push
// expected responses into queues; a monitor pops and compares them on each
// B/R handshake and also tracks the start pulse.
module tb_simon_cfg_axil;
  import simon_cfg_pkg::*;

  localparam int KW = 4;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     s_awaddr;
  logic [2:0]        s_awprot;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [AW-1:0]     s_araddr;
  logic [2:0]        s_arprot;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [KW*32-1:0]  init_key;
  logic              key_compute_start;
  logic              key_busy;

  simon_cfg_axil #(.KEY_WORDS(KW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_awaddr         (s_awaddr),
    .s_awprot         (s_awprot),
    .s_awvalid        (s_awvalid),
    .s_awready        (s_awready),
    .s_wdata          (s_wdata),
    .s_wstrb          (s_wstrb),
    .s_wvalid         (s_wvalid),
    .s_wready         (s_wready),
    .s_bresp          (s_bresp),
    .s_bvalid         (s_bvalid),
    .s_bready         (s_bready),
    .s_araddr         (s_araddr),
    .s_arprot         (s_arprot),
    .s_arvalid        (s_arvalid),
    .s_arready        (s_arready),
    .s_rdata          (s_rdata),
    .s_rresp          (s_rresp),
    .s_rvalid         (s_rvalid),
    .s_rready         (s_rready),
    .init_key         (init_key),
    .key_compute_start(key_compute_start),
    .key_busy         (key_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int last_brise_cyc = -1;
  int last_hs_cyc = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops on B/R handshakes; start pulse tracking.
  initial begin
    logic  prev_pulse;
    logic  prev_bvalid;
    logic [1:0] eb;
    rexp_t er;
    prev_pulse  = 1'b0;
    prev_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (key_compute_start) begin
          check("start_pulse_width", 128'(prev_pulse), 128'd0);
          pulse_cnt++;
          last_pulse_cyc = cyc;
        end
        if (s_bvalid && !prev_bvalid) last_brise_cyc = cyc;
        if (s_bvalid && s_bready) begin
          if (exp_b.size() == 0) flag_fail("unexpected_bresp");
          else begin
            eb = exp_b.pop_front();
            check("bresp", 128'(s_bresp), 128'(eb));
          end
        end
        if (s_rvalid && s_rready) begin
          if (exp_r.size() == 0) flag_fail("unexpected_rdata");
          else begin
            er = exp_r.pop_front();
            check("rresp", 128'(s_rresp), 128'(er.resp));
            check("rdata", 128'(s_rdata), 128'(er.data));
          end
        end
      end
      prev_pulse  = key_compute_start;
      prev_bvalid = s_bvalid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Idle cycles between the two halves of a split write; no response allowed.
  task automatic wait_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      check("no_b_one_side", 128'(s_bvalid), 128'd0);
      @(posedge clk); #1;
    end
  endtask

  // mode 0: AW then W, 1: together, 2: W then AW. hold: cycles of BREADY low.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp,
                           input int mode, input int gap, input int hold);
    bit aw_done, w_done, aw_fire, w_fire, b_done;
    int guard;
    exp_b.push_back(resp);
    aw_done = 0; w_done = 0; guard = 0;
    if (hold > 0) s_bready = 1'b0;
    if (mode != 2) begin s_awaddr = addr; s_awvalid = 1'b1; end
    if (mode != 0) begin s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; end
    while (!(aw_done && w_done) && guard < 40) begin
      @(negedge clk);
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      if (aw_fire || w_fire) last_hs_cyc = cyc;
      @(posedge clk); #1;
      if (aw_fire) begin s_awvalid = 1'b0; aw_done = 1; end
      if (w_fire)  begin s_wvalid  = 1'b0; w_done  = 1; end
      if (mode == 0 && aw_fire) begin
        wait_gap(gap);
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
      end
      if (mode == 2 && w_fire) begin
        wait_gap(gap);
        s_awaddr = addr; s_awvalid = 1'b1;
      end
      guard++;
    end
    if (!(aw_done && w_done)) begin
      flag_fail("write_addr_data_timeout");
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end
    if (hold > 0) begin
      guard = 0;
      while (!s_bvalid && guard < 20) begin @(posedge clk); #1; guard++; end
      if (!s_bvalid) flag_fail("bvalid_for_hold_timeout");
      repeat (hold) begin
        @(negedge clk);
        check("bvalid_held", 128'(s_bvalid), 128'd1);
        check("bresp_held", 128'(s_bresp), 128'(resp));
        check("awready_low_while_b", 128'(s_awready), 128'd0);
        check("wready_low_while_b", 128'(s_wready), 128'd0);
      end
      @(posedge clk); #1;
      s_bready = 1'b1;
    end
    b_done = 0; guard = 0;
    while (!b_done && guard < 40) begin
      @(negedge clk);
      b_done = s_bvalid && s_bready;
      @(posedge clk); #1;
      guard++;
    end
    if (!b_done) flag_fail("write_resp_timeout");
  endtask

  // hold: cycles of RREADY low after the AR handshake.
  task automatic axi_read(input logic [7:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int hold);
    rexp_t e;
    bit ar_done, r_done;
    int guard;
    e.resp = resp; e.data = data;
    exp_r.push_back(e);
    if (hold > 0) s_rready = 1'b0;
    s_araddr = addr; s_arvalid = 1'b1;
    ar_done = 0; guard = 0;
    while (!ar_done && guard < 40) begin
      @(negedge clk);
      ar_done = s_arvalid && s_arready;
      @(posedge clk); #1;
      guard++;
    end
    s_arvalid = 1'b0;
    if (!ar_done) flag_fail("read_addr_timeout");
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("rvalid_held", 128'(s_rvalid), 128'd1);
        check("rdata_held", 128'(s_rdata), 128'(data));
        check("rresp_held", 128'(s_rresp), 128'(resp));
        check("arready_low_while_r", 128'(s_arready), 128'd0);
      end
      @(posedge clk); #1;
      s_rready = 1'b1;
    end
    r_done = 0; guard = 0;
    while (!r_done && guard < 40) begin
      @(negedge clk);
      r_done = s_rvalid && s_rready;
      @(posedge clk); #1;
      guard++;
    end
    if (!r_done) flag_fail("read_data_timeout");
  endtask

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic [31:0] key_vec [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0;
    s_rready = 1'b1;
    key_busy = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 128'(s_awready), 128'd0);
    check("rst_bvalid", 128'(s_bvalid), 128'd0);
    check("rst_rvalid", 128'(s_rvalid), 128'd0);
    check("rst_start", 128'(key_compute_start), 128'd0);
    check("rst_init_key", init_key, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", 128'(s_awready), 128'd1);
    check("idle_wready", 128'(s_wready), 128'd1);
    check("idle_arready", 128'(s_arready), 128'd1);
    @(posedge clk); #1;
    axi_read(8'h20, 32'h0000_0002, OK, 0);
    axi_read(8'h24, 32'h0000_0400, OK, 0);

    // Key load with auto-start; AW ahead of W.
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(4 * i), key_vec[i], 4'hF, OK, 0, 1, 0);
      if (i < 3) check("no_early_pulse", 128'(pulse_cnt), 128'd0);
    end
    check("auto_pulse_count", 128'(pulse_cnt), 128'd1);
    check("auto_pulse_with_bvalid", 128'(last_pulse_cyc), 128'(last_brise_cyc));
    check("init_key_loaded", init_key, 128'h44444444_33333333_22222222_11111111);
    axi_read(8'h24, 32'h0000_0400, OK, 0);
    axi_read(8'h08, 32'h3333_3333, OK, 0);

    // Simultaneous AW/W latency, then byte strobes with W ahead of AW.
    axi_write(8'h04, 32'hAABB_CCDD, 4'hF, OK, 1, 0, 0);
    check("simul_b_latency", 128'(last_brise_cyc - last_hs_cyc), 128'd2);
    axi_write(8'h04, 32'h0000_0011, 4'b0001, OK, 2, 2, 0);
    axi_read(8'h04, 32'hAABB_CC11, OK, 0);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'b0000, OK, 1, 0, 0);
    axi_read(8'h08, 32'h3333_3333, OK, 0);
    check("no_pulse_partial", 128'(pulse_cnt), 128'd1);

    // Busy core: key lock, suppressed start, overrun set and clear.
    @(posedge clk); #1;
    key_busy = 1'b1;
    axi_write(8'h00, 32'h1234_5678, 4'hF, ERR, 1, 0, 0);
    axi_read(8'h00, 32'h1111_1111, OK, 0);
    axi_write(8'h20, 32'h0000_0001, 4'hF, OK, 1, 0, 0);
    check("busy_start_suppressed", 128'(pulse_cnt), 128'd1);
    axi_read(8'h24, 32'h0000_0405, OK, 0);
    axi_write(8'h20, 32'h0000_0004, 4'hF, ERR, 1, 0, 0);
    check("busy_clear_ignored", init_key, 128'h44444444_33333333_AABBCC11_11111111);
    axi_write(8'h24, 32'h0000_0004, 4'hF, OK, 1, 0, 0);
    axi_read(8'h24, 32'h0000_0401, OK, 0);
    key_busy = 1'b0;
    axi_read(8'h24, 32'h0000_0400, OK, 0);
    axi_read(8'h20, 32'h0000_0000, OK, 0);

    // Unmapped offsets and ignored upper address bits.
    axi_read(8'h30, 32'h0000_0000, ERR, 0);
    axi_write(8'h10, 32'h5555_5555, 4'hF, ERR, 1, 0, 0);
    axi_read(8'h10, 32'h0000_0000, ERR, 0);
    axi_read(8'h28, 32'h0000_0000, ERR, 0);
    axi_read(8'hC4, 32'hAABB_CC11, OK, 0);

    // Back-pressure on B and R.
    axi_write(8'h20, 32'h0000_0002, 4'hF, OK, 1, 0, 5);
    axi_read(8'h08, 32'h3333_3333, OK, 5);

    // Explicit start, then clear with start (clear wins).
    axi_write(8'h20, 32'h0000_0003, 4'hF, OK, 0, 0, 0);
    check("ctrl_pulse_count", 128'(pulse_cnt), 128'd2);
    check("ctrl_pulse_with_bvalid", 128'(last_pulse_cyc), 128'(last_brise_cyc));
    axi_write(8'h20, 32'h0000_0005, 4'hF, OK, 0, 0, 0);
    check("clear_drops_start", 128'(pulse_cnt), 128'd2);
    check("clear_zeroes_key", init_key, 128'd0);
    axi_read(8'h20, 32'h0000_0000, OK, 0);

    // Reset with AW accepted and W still pending.
    axi_write(8'h08, 32'h7777_7777, 4'hF, OK, 1, 0, 0);
    check("key2_loaded", init_key, 128'h00000000_77777777_00000000_00000000);
    s_awaddr = 8'h00; s_awvalid = 1'b1;
    @(negedge clk);
    check("mid_aw_ready", 128'(s_awready), 128'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_bvalid", 128'(s_bvalid), 128'd0);
      @(posedge clk); #1;
    end
    check("mid_rst_init_key", init_key, 128'd0);
    rst = 1'b0;
    axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, OK, 2, 3, 0);
    axi_read(8'h00, 32'h0000_0000, OK, 0);
    axi_read(8'h04, 32'hDEAD_BEEF, OK, 0);
    axi_read(8'h20, 32'h0000_0002, OK, 0);
    axi_read(8'h24, 32'h0000_0400, OK, 0);
    check("final_pulse_count", 128'(pulse_cnt), 128'd2);

    repeat (3) @(posedge clk);
    check("b_queue_drained", 128'(exp_b.size()), 128'd0);
    check("r_queue_drained", 128'(exp_r.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
